// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the 1:2 buffered demultiplexer slice.
//   DEMUX_WIDTH : default data word width
//   DEMUX_DEPTH : default per-output FIFO depth (power of two, >= 2)
//   SEL_A/SEL_B : encoding of the per-word steering bit
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int DEMUX_WIDTH = 32;
  localparam int DEMUX_DEPTH = 2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : demux_pkg

// File: rtl/sync_fifo_buf.sv
// -----------------------------------------------------------------------------
// sync_fifo_buf
// Small synchronous FIFO with a show-ahead head and an occupancy count.
// Full/empty come from the count, so the pointers can simply wrap modulo DEPTH.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   WIDTH-bit word to store
//   pop        in   advance the head (ignored when empty)
//   head_data  out  current head word, 0 when empty
//   empty      out  no words stored
//   full       out  DEPTH words stored
//   count      out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_buf
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEMUX_WIDTH,
  parameter  int DEPTH = DEMUX_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Empty FIFO presents zero rather than stale storage.
  assign head_data = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: plain increment wraps modulo DEPTH.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;  // idle, or push and pop together
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; its contents are only
  // observable through head_data while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule : sync_fifo_buf

// File: rtl/demux_32b_1x2_buf.sv
// -----------------------------------------------------------------------------
// demux_32b_1x2_buf
// Steers one producer stream to consumer A or B by a per-word select bit.
// Each consumer has its own FIFO, so a stalled consumer only blocks words
// bound for itself once its FIFO is full.
//
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   in_data    word to steer
//   in_sel     SEL_A (0) routes to A, SEL_B (1) routes to B
//   in_valid   producer offers in_data/in_sel
//   in_ready   selected FIFO has space this cycle
//   a_data/a_valid/a_ready, b_data/b_valid/b_ready   output streams
//   a_count/b_count   per-output occupancy
// -----------------------------------------------------------------------------
module demux_32b_1x2_buf
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEMUX_WIDTH,
  parameter  int DEPTH = DEMUX_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);

  logic a_empty, a_full;
  logic b_empty, b_full;
  logic accept;
  logic push_a, push_b;

  // Ready depends only on the select and registered fullness; a pop in the
  // same cycle does not free space, which keeps consumer ready off this path.
  assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;
  assign accept   = in_valid && in_ready;
  assign push_a   = accept && (in_sel == SEL_A);
  assign push_b   = accept && (in_sel == SEL_B);

  assign a_valid = !a_empty;
  assign b_valid = !b_empty;

  sync_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .push_data (in_data),
    .pop       (a_ready),
    .head_data (a_data),
    .empty     (a_empty),
    .full      (a_full),
    .count     (a_count)
  );

  sync_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .push_data (in_data),
    .pop       (b_ready),
    .head_data (b_data),
    .empty     (b_empty),
    .full      (b_full),
    .count     (b_count)
  );

endmodule : demux_32b_1x2_buf

// File: tb/tb_demux_32b_1x2_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_32b_1x2_buf
// Self-checking bench: directed scenarios plus a randomized stream, compared
// every cycle against a queue-based model of two bounded FIFOs.
// -----------------------------------------------------------------------------
module tb_demux_32b_1x2_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  demux_32b_1x2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each output is just a bounded queue of words.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  // Scoreboard: words accepted per output, and words seen leaving the DUT.
  logic [WIDTH-1:0] sent_a[$];
  logic [WIDTH-1:0] sent_b[$];
  logic [WIDTH-1:0] got_a[$];
  logic [WIDTH-1:0] got_b[$];
  bit               last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against model with the inputs already
  // driven, then advance the model by the handshakes that fire at the edge.
  task automatic tick();
    bit m_rdy, popa, popb;
    #1;
    m_rdy = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    popa  = a_ready && (qa.size() != 0);
    popb  = b_ready && (qb.size() != 0);
    check("in_ready", in_ready, m_rdy);
    check("a_valid",  a_valid,  qa.size() != 0);
    check("b_valid",  b_valid,  qb.size() != 0);
    check("a_data",   a_data,   (qa.size() != 0) ? qa[0] : '0);
    check("b_data",   b_data,   (qb.size() != 0) ? qb[0] : '0);
    check("a_count",  a_count,  qa.size());
    check("b_count",  b_count,  qb.size());
    if (a_valid && a_ready) got_a.push_back(a_data);
    if (b_valid && b_ready) got_b.push_back(b_data);
    last_acc = in_valid && m_rdy;
    @(posedge clk);
    if (popa) void'(qa.pop_front());
    if (popb) void'(qb.pop_front());
    if (last_acc) begin
      if (in_sel) begin qb.push_back(in_data); sent_b.push_back(in_data); end
      else        begin qa.push_back(in_data); sent_a.push_back(in_data); end
    end
    #1;
  endtask

  task automatic offer(input logic [WIDTH-1:0] d, input logic s);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
    in_sel   = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    idle();
    a_ready = 1'b1;
    b_ready = 1'b1;
    while ((qa.size() != 0 || qb.size() != 0) && guard < 20) begin
      tick();
      guard++;
    end
    check("drain_bound", guard < 20, 1);
    tick();
  endtask

  task automatic clear_logs();
    sent_a.delete(); sent_b.delete();
    got_a.delete();  got_b.delete();
  endtask

  initial begin
    rst      = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    idle();

    // ---------------- power-on reset ----------------
    #1 rst = 1'b1;
    #2;
    check("por_a_valid", a_valid, 0);
    check("por_b_valid", b_valid, 0);
    check("por_a_count", a_count, 0);
    check("por_b_count", b_count, 0);
    check("por_a_data",  a_data,  0);
    @(posedge clk);
    #5 rst = 1'b0;

    // ---------------- basic steer ----------------
    a_ready = 1'b1;
    b_ready = 1'b1;
    offer(32'h1111_1111, 1'b0);
    tick();
    offer(32'hBBBB_BBBB, 1'b1);
    #1;
    check("steer_a_n1", a_data, 32'h1111_1111);
    tick();
    idle();
    #1;
    check("steer_b_n2", b_data, 32'hBBBB_BBBB);
    check("steer_a_gone", a_valid, 0);
    tick();
    check("steer_a_cnt0", a_count, 0);
    check("steer_b_cnt0", b_count, 0);

    // ---------------- full A and backpressure ----------------
    clear_logs();
    a_ready = 1'b0;
    offer(32'hA0, 1'b0); tick();
    offer(32'hA1, 1'b0); tick();
    offer(32'hA2, 1'b0);
    #1;
    check("bp_a_count2", a_count, 2);
    check("bp_in_ready0", in_ready, 0);
    tick();
    a_ready = 1'b1;           // pops A0; A2 still refused (was full)
    tick();
    check("bp_a2_held", last_acc, 0);
    a_ready = 1'b0;
    tick();                   // A2 accepted now that A has a slot
    check("bp_a2_taken", last_acc, 1);

    // ---------------- other side not blocked ----------------
    offer(32'hB0, 1'b1);
    #1;
    check("nb_in_ready1", in_ready, 1);
    tick();
    idle();
    #1;
    check("nb_b_valid", b_valid, 1);
    check("nb_a_count2", a_count, 2);
    drain();
    check("bp_order_n", got_a.size(), 3);
    if (got_a.size() == 3) begin
      check("bp_order0", got_a[0], 32'hA0);
      check("bp_order1", got_a[1], 32'hA1);
      check("bp_order2", got_a[2], 32'hA2);
    end

    // ---------------- simultaneous push and pop ----------------
    a_ready = 1'b0;
    offer(32'h5, 1'b0); tick();
    a_ready = 1'b1;
    offer(32'h6, 1'b0);
    #1;
    check("pp_head5", a_data, 32'h5);
    tick();
    idle();
    a_ready = 1'b0;
    #1;
    check("pp_cnt1", a_count, 1);
    check("pp_head6", a_data, 32'h6);
    drain();

    // ---------------- reset mid-stream ----------------
    a_ready = 1'b0;
    offer(32'hC0, 1'b0); tick();
    offer(32'hC1, 1'b0); tick();
    idle();
    #2 rst = 1'b1;
    #1;
    check("mr_a_valid", a_valid, 0);
    check("mr_a_count", a_count, 0);
    check("mr_a_data",  a_data,  0);
    qa.delete();
    qb.delete();
    #1 rst = 1'b0;
    offer(32'hD0, 1'b0);
    tick();
    idle();
    #1;
    check("mr_post_valid", a_valid, 1);
    check("mr_post_data",  a_data,  32'hD0);
    drain();

    // ---------------- randomized stream with wrap-around ----------------
    clear_logs();
    begin
      int sent  = 0;
      int guard = 0;
      while (sent < 40 && guard < 2000) begin
        if (!in_valid && ($urandom_range(3) != 0))
          offer($urandom, (sent < 10) ? sent[0] : 1'($urandom_range(1)));
        a_ready = 1'($urandom_range(1));
        b_ready = 1'($urandom_range(1));
        tick();
        check("rnd_a_max", a_count <= DEPTH, 1);
        check("rnd_b_max", b_count <= DEPTH, 1);
        if (last_acc) begin
          sent++;
          idle();
        end
        guard++;
      end
      check("rnd_bound", guard < 2000, 1);
    end
    drain();
    check("sb_a_n", got_a.size(), sent_a.size());
    check("sb_b_n", got_b.size(), sent_b.size());
    for (int i = 0; i < sent_a.size() && i < got_a.size(); i++)
      check("sb_a_word", got_a[i], sent_a[i]);
    for (int i = 0; i < sent_b.size() && i < got_b.size(); i++)
      check("sb_b_word", got_b[i], sent_b[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_demux_32b_1x2_buf

// File: doc/demux_32b_1x2_buf.md
Name: demux_32b_1x2_buf

Overview:
- Inverse of the datapath 2:1 select mux: one 32-bit producer stream is steered to one of two consumer streams (A or B) by a per-word select bit.
- Each output has its own small FIFO, so a stalled consumer does not block words bound for the other consumer until its own FIFO fills.
- Sits between a result producer (ALU or load path) and two sinks (for example, register write-back and a store/trace port).

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 2, entries per output FIFO; must be a power of two, at least 2.
- CW, $clog2(DEPTH)+1, occupancy count width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  WIDTH  word to steer.
- in_sel  in  1  0 = route to A, 1 = route to B.
- in_valid  in  1  producer offers in_data/in_sel.
- in_ready  out  1  block accepts this cycle.
- a_data  out  WIDTH  head of FIFO A.
- a_valid  out  1  FIFO A non-empty.
- a_ready  in  1  consumer A takes the head.
- b_data  out  WIDTH  head of FIFO B.
- b_valid  out  1  FIFO B non-empty.
- b_ready  in  1  consumer B takes the head.
- a_count  out  CW  FIFO A occupancy.
- b_count  out  CW  FIFO B occupancy.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is asynchronous and active-high. While asserted: pointers = 0, counts = 0, a_valid = b_valid = 0, a_data = b_data = 0.
  - Reset mid-operation discards all stored words immediately. No output handshake completes in the reset cycle.
- in_ready:
  - in_ready = !full(selected FIFO), where selected = in_sel.
  - It is combinational on in_sel and registered counts only; it has no dependence on a_ready or b_ready.
- Push and pop:
  - A word is accepted when in_valid && in_ready. It is written to the tail of the selected FIFO at the rising edge.
  - in_sel and in_data are sampled only on accept. Words offered while in_valid = 0 have no effect.
  - Pop A when a_valid && a_ready; pop B likewise. Each pop advances the head at the edge.
  - a_data and b_data always present the current head. They are 0 when the FIFO is empty.
- Latency:
  - Accept in cycle N gives out_valid in cycle N+1 when the target FIFO was empty.
  - There is no same-cycle pass-through.
- Ordering:
  - Order is preserved within each output.
  - No ordering is implied between A and B.
- Full FIFO:
  - When the selected FIFO is full, in_ready = 0, even if that FIFO pops in the same cycle. This is a conservative rule that avoids a ready-to-ready combinational path.
  - A full A does not block a word with in_sel = 1 while B has space.
- Simultaneous push and pop on the same non-full FIFO: count is unchanged; head and tail both advance.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided by count, not by pointer compare.
- Count range: 0..DEPTH. It never exceeds DEPTH and never underflows. A pop on empty is impossible because valid = 0.
- Protocol obligations on the environment (checked by the bench):
  - in_valid held with stable in_data/in_sel until in_ready.
  - Consumers may toggle ready freely.
  - out_valid and out_data, once asserted, remain stable until popped.

Decomposition:
- Shared package, demux_pkg:
  - WIDTH default.
  - DEPTH default.
  - Select encoding constants SEL_A = 1'b0 and SEL_B = 1'b1.
- One sub-module, sync_fifo_buf (WIDTH, DEPTH):
  - Ports: clk, rst, push, push_data, pop, head_data, empty, full, count.
  - Instantiated twice.
- Top level contains only steering logic: push_a = accept && !in_sel, push_b = accept && in_sel, plus the in_ready mux.

Test Plan:
- Reset mid-stream: fill A with 2 words, assert rst asynchronously between edges -> a_valid = 0, a_count = 0, a_data = 0 immediately; first post-reset accept appears at A the next cycle.
- Basic steer: a_ready = b_ready = 1; send 0x11111111 sel 0, then 0xBBBBBBBB sel 1 -> A shows 0x11111111 in cycle N+1, B shows 0xBBBBBBBB in cycle N+2; counts return to 0.
- Full and backpressure: a_ready = 0; send 0xA0, 0xA1, 0xA2 all sel 0 -> first two accepted, a_count = 2, in_ready = 0 on 0xA2; raise a_ready one cycle -> pops 0xA0; 0xA2 accepted next cycle; final drain order is A0, A1, A2.
- Non-blocking other side: A full with a_ready = 0; send 0xB0 sel 1 -> in_ready = 1, b_valid = 1 next cycle, a_count stays 2.
- Simultaneous push and pop: A at count 1 (0x5), a_ready = 1, push 0x6 sel 0 -> a_count stays 1, a_data goes 0x5 to 0x6.
- Wrap-around: stream 10 words alternating sel 0/1 with random ready -> each output receives its words in order, counts never exceed 2, no word lost or duplicated (scoreboard).
